// File: rtl/bus_read_arbiter.sv
// bus_read_arbiter
//   Shares one memory read port between the instruction-fetch read bus (i_*)
//   and the data-load read bus (d_*). Each accepted address request records its
//   source in an in-order tag FIFO. The tag at the FIFO head routes the next
//   memory response back to the requester that issued it.
//
// Parameters
//   ADDR_WIDTH       address width of i_raddr / d_raddr / m_raddr
//   DATA_WIDTH       data width of i_rdata / d_rdata / m_rdata
//   MAX_OUTSTANDING  tag FIFO depth, i.e. accepted but unanswered reads (>=1)
//
// Ports
//   clk, rst                         rising-edge clock, async active-high reset
//   i_raddr_valid/ready, i_raddr     fetch address channel (slave side)
//   i_rdata_valid/ready, i_rdata     fetch data channel (master side)
//   d_raddr_valid/ready, d_raddr     load address channel (slave side)
//   d_rdata_valid/ready, d_rdata     load data channel (master side)
//   m_raddr_valid/ready, m_raddr     memory address channel (master side)
//   m_rdata_valid/ready, m_rdata     memory data channel (slave side)
//
// Configuration
//   ARB_D_PRIORITY_EN  when defined, d_* wins every tie (fixed priority);
//                      otherwise ties alternate round-robin.

module bus_read_arbiter #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_raddr_valid,
    output logic                  i_raddr_ready,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic                  i_rdata_valid,
    input  logic                  i_rdata_ready,
    output logic [DATA_WIDTH-1:0] i_rdata,
    input  logic                  d_raddr_valid,
    output logic                  d_raddr_ready,
    input  logic [ADDR_WIDTH-1:0] d_raddr,
    output logic                  d_rdata_valid,
    input  logic                  d_rdata_ready,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  m_raddr_valid,
    input  logic                  m_raddr_ready,
    output logic [ADDR_WIDTH-1:0] m_raddr,
    input  logic                  m_rdata_valid,
    output logic                  m_rdata_ready,
    input  logic [DATA_WIDTH-1:0] m_rdata
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    typedef enum logic {
        SRC_I = 1'b0,
        SRC_D = 1'b1
    } src_t;

    // The lock flag and the locked source are folded into one state variable.
    typedef enum logic [1:0] {
        ST_FREE,
        ST_LOCK_I,
        ST_LOCK_D
    } state_t;

    state_t state, state_nxt;
    src_t   grant;
    src_t   head;
    logic   grant_valid;
    logic   req_xfer;
    logic   rsp_xfer;

    logic [MAX_OUTSTANDING-1:0] tags;
    logic [PTR_W-1:0]           wr_ptr;
    logic [PTR_W-1:0]           rd_ptr;
    logic [CNT_W-1:0]           count;
    logic                       full;
    logic                       empty;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full     = (count == CNT_W'(MAX_OUTSTANDING));
    assign empty    = (count == '0);
    assign head     = src_t'(tags[rd_ptr]);
    assign req_xfer = m_raddr_valid & m_raddr_ready;
    assign rsp_xfer = m_rdata_valid & m_rdata_ready;
    assign i_rdata  = m_rdata;
    assign d_rdata  = m_rdata;

`ifndef ARB_D_PRIORITY_EN
    src_t last_grant;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)           last_grant <= SRC_D;
        else if (req_xfer) last_grant <= grant;
    end
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_FREE;
        else     state <= state_nxt;
    end

    // Next state: hold the grant while an offered address waits for acceptance
    always_comb begin
        state_nxt = state;
        case (state)
            ST_FREE: begin
                if (m_raddr_valid && !m_raddr_ready)
                    state_nxt = (grant == SRC_I) ? ST_LOCK_I : ST_LOCK_D;
            end
            ST_LOCK_I, ST_LOCK_D: begin
                if (req_xfer) state_nxt = ST_FREE;
            end
            default: state_nxt = ST_FREE;
        endcase
    end

    // Outputs: grant selection, address mux, handshakes, response routing.
    // Every valid/ready output is forced low while rst is asserted.
    always_comb begin
        grant = SRC_I;
        case (state)
            ST_LOCK_I: grant = SRC_I;
            ST_LOCK_D: grant = SRC_D;
            default: begin
                if (i_raddr_valid && d_raddr_valid)
`ifdef ARB_D_PRIORITY_EN
                    grant = SRC_D;
`else
                    grant = (last_grant == SRC_D) ? SRC_I : SRC_D;
`endif
                else if (d_raddr_valid)
                    grant = SRC_D;
                else
                    grant = SRC_I;
            end
        endcase

        grant_valid   = (grant == SRC_I) ? i_raddr_valid : d_raddr_valid;
        m_raddr       = (grant == SRC_I) ? i_raddr : d_raddr;
        m_raddr_valid = grant_valid && !full && !rst;
        i_raddr_ready = m_raddr_ready && (grant == SRC_I) && !full && !rst;
        d_raddr_ready = m_raddr_ready && (grant == SRC_D) && !full && !rst;

        i_rdata_valid = m_rdata_valid && !empty && (head == SRC_I) && !rst;
        d_rdata_valid = m_rdata_valid && !empty && (head == SRC_D) && !rst;
        m_rdata_ready = ((head == SRC_I) ? i_rdata_ready : d_rdata_ready) && !empty && !rst;
    end

    // Tag FIFO
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tags   <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (req_xfer) begin
                tags[wr_ptr] <= grant;
                wr_ptr       <= next_ptr(wr_ptr);
            end
            if (rsp_xfer) rd_ptr <= next_ptr(rd_ptr);
            case ({req_xfer, rsp_xfer})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule
